// File: rtl/systolic_tile_ctrl.sv
// Purpose: tile sequencer for a ROWS x COLS output-stationary systolic array (load, skewed MAC, row drain).
// Latency: K..2K load cycles, then exactly K+ROWS+COLS MAC cycles, then one cycle per accepted result row.
// Backpressure: x/w ready drop after K beats or when all lane FIFOs are full; result rows wait for out_send_rdy.
module systolic_tile_ctrl #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int K    = 4
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      x_recv_val,
   output logic                                      x_recv_rdy,
   input  logic                                      w_recv_val,
   output logic                                      w_recv_rdy,
   input  logic [ROWS-1:0]                           x_fifo_full,
   input  logic [ROWS-1:0]                           x_fifo_empty,
   output logic [ROWS-1:0]                           x_fifo_wen,
   output logic [ROWS-1:0]                           x_fifo_ren,
   input  logic [COLS-1:0]                           w_fifo_full,
   input  logic [COLS-1:0]                           w_fifo_empty,
   output logic [COLS-1:0]                           w_fifo_wen,
   output logic [COLS-1:0]                           w_fifo_ren,
   output logic                                      mac_en,
   output logic                                      mac_clr,
   output logic                                      out_send_val,
   input  logic                                      out_send_rdy,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
   output logic                                      err,
   output logic [1:0]                                state_o
);

   localparam int L  = K + ROWS + COLS;
   localparam int KW = $clog2(K + 1);
   localparam int CW = $clog2(L);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [1:0] S_LOAD = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   logic [1:0]      state;
   logic [KW-1:0]   xc;
   logic [KW-1:0]   wc;
   logic [CW-1:0]   c;
   logic [RW-1:0]   r;
   logic            err_q;

   logic            in_load, in_mac, in_out;
   logic            x_rdy_i, w_rdy_i, x_hs, w_hs;
   logic            x_done, w_done, load_done;
   logic            mac_last, row_last, out_hs;
   logic            underflow;
   logic [ROWS-1:0] x_ren_i;
   logic [COLS-1:0] w_ren_i;

   assign in_load = (state == S_LOAD);
   assign in_mac  = (state == S_MAC);
   assign in_out  = (state == S_OUT);

   // Load side: each stream counts to K on its own; the tile closes on the
   // cycle the later of the two streams takes its last beat.
   assign x_rdy_i   = in_load & (xc != KW'(K)) & ~(&x_fifo_full);
   assign w_rdy_i   = in_load & (wc != KW'(K)) & ~(&w_fifo_full);
   assign x_hs      = x_recv_val & x_rdy_i;
   assign w_hs      = w_recv_val & w_rdy_i;
   assign x_done    = (xc == KW'(K)) | (x_hs & (xc == KW'(K - 1)));
   assign w_done    = (wc == KW'(K)) | (w_hs & (wc == KW'(K - 1)));
   assign load_done = in_load & x_done & w_done;

   assign mac_last = in_mac & (c == CW'(L - 1));
   assign row_last = (r == RW'(ROWS - 1));
   assign out_hs   = in_out & out_send_rdy;

   // Diagonal skew: lane i reads during MAC cycles i .. i+K-1.
   always_comb begin
      x_ren_i = '0;
      w_ren_i = '0;
      for (int i = 0; i < ROWS; i++)
         x_ren_i[i] = in_mac & (int'(c) >= i) & (int'(c) < i + K);
      for (int j = 0; j < COLS; j++)
         w_ren_i[j] = in_mac & (int'(c) >= j) & (int'(c) < j + K);
   end

   assign underflow = (|(x_ren_i & x_fifo_empty)) | (|(w_ren_i & w_fifo_empty));

   // Tile sequencer: LOAD -> MAC (fixed L cycles) -> OUT (ROWS handshakes) -> LOAD.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_LOAD;
         xc    <= '0;
         wc    <= '0;
         c     <= '0;
         r     <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (load_done) begin
                  state <= S_MAC;
                  c     <= '0;
                  xc    <= '0;
                  wc    <= '0;
               end else begin
                  if (x_hs) xc <= xc + KW'(1);
                  if (w_hs) wc <= wc + KW'(1);
               end
            end
            S_MAC: begin
               if (mac_last) begin
                  state <= S_OUT;
                  r     <= '0;
               end else begin
                  c <= c + CW'(1);
               end
            end
            S_OUT: begin
               if (out_hs) begin
                  if (row_last) begin
                     state <= S_LOAD;
                     r     <= '0;
                     xc    <= '0;
                     wc    <= '0;
                  end else begin
                     r <= r + RW'(1);
                  end
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

   // Sticky underflow: any lane read while its FIFO reports empty; only rst clears it.
   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else if (underflow) err_q <= 1'b1;
   end

   // Every output is forced low while rst is asserted, even before state has been cleared.
   assign x_recv_rdy   = ~rst & x_rdy_i;
   assign w_recv_rdy   = ~rst & w_rdy_i;
   assign x_fifo_wen   = {ROWS{~rst & x_hs}};
   assign w_fifo_wen   = {COLS{~rst & w_hs}};
   assign x_fifo_ren   = rst ? '0 : x_ren_i;
   assign w_fifo_ren   = rst ? '0 : w_ren_i;
   assign mac_en       = ~rst & in_mac;
   assign mac_clr      = ~rst & load_done;
   assign out_send_val = ~rst & in_out;
   assign out_row      = (~rst & in_out) ? r : '0;
   assign err          = ~rst & err_q;
   assign state_o      = rst ? 2'd0 : state;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Bench for systolic_tile_ctrl: table-driven load vectors, directed tile sequences and a random run,
// every cycle checked against a tile-level reference model; a second 2x5 K=3 instance free-runs.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
module tb_systolic_tile_ctrl;

   localparam int R  = 4;
   localparam int C  = 4;
   localparam int KK = 4;
   localparam int L  = KK + R + C;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       x_val, w_val, out_rdy;
   logic [3:0] x_full, x_empty, w_full, w_empty;
   logic       a_xr, a_wr, a_men, a_mclr, a_oval, a_err;
   logic [3:0] a_xwen, a_xren, a_wwen, a_wren;
   logic [1:0] a_orow, a_st;

   logic       b_xr, b_wr, b_men, b_mclr, b_oval, b_err, b_orow;
   logic [1:0] b_xwen, b_xren, b_st;
   logic [4:0] b_wwen, b_wren;

   systolic_tile_ctrl #(.ROWS(R), .COLS(C), .K(KK)) dut_a (
      .clk(clk), .rst(rst),
      .x_recv_val(x_val), .x_recv_rdy(a_xr),
      .w_recv_val(w_val), .w_recv_rdy(a_wr),
      .x_fifo_full(x_full), .x_fifo_empty(x_empty), .x_fifo_wen(a_xwen), .x_fifo_ren(a_xren),
      .w_fifo_full(w_full), .w_fifo_empty(w_empty), .w_fifo_wen(a_wwen), .w_fifo_ren(a_wren),
      .mac_en(a_men), .mac_clr(a_mclr),
      .out_send_val(a_oval), .out_send_rdy(out_rdy), .out_row(a_orow),
      .err(a_err), .state_o(a_st)
   );

   systolic_tile_ctrl #(.ROWS(2), .COLS(5), .K(3)) dut_b (
      .clk(clk), .rst(rst),
      .x_recv_val(1'b1), .x_recv_rdy(b_xr),
      .w_recv_val(1'b1), .w_recv_rdy(b_wr),
      .x_fifo_full(2'b00), .x_fifo_empty(2'b00), .x_fifo_wen(b_xwen), .x_fifo_ren(b_xren),
      .w_fifo_full(5'b00000), .w_fifo_empty(5'b00000), .w_fifo_wen(b_wwen), .w_fifo_ren(b_wren),
      .mac_en(b_men), .mac_clr(b_mclr),
      .out_send_val(b_oval), .out_send_rdy(1'b1), .out_row(b_orow),
      .err(b_err), .state_o(b_st)
   );

   typedef struct packed {
      logic       xr;
      logic       wr;
      logic [3:0] xwen;
      logic [3:0] xren;
      logic [3:0] wwen;
      logic [3:0] wren;
      logic       men;
      logic       mclr;
      logic       oval;
      logic [1:0] orow;
      logic       err;
      logic [1:0] st;
   } aout_t;

   typedef struct {
      bit         xv, wv, xfull;
      bit         exr, ewr, eclr;
      logic [1:0] est;
   } vec_t;

   int    errors = 0;
   int    checks = 0;
   aout_t snap;

   // Tile-level reference: phase, beats taken per stream, MAC cycle, rows drained.
   int m_ph = 0, m_xc = 0, m_wc = 0, m_c = 0, m_r = 0;
   bit m_err = 1'b0;
   bit e_xhs, e_whs, e_clr, e_uf;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock cycle: sample, compare against the model, take the edge, advance the model.
   task automatic tick();
      aout_t e;
      #4;
      snap = {a_xr, a_wr, a_xwen, a_xren, a_wwen, a_wren, a_men, a_mclr, a_oval, a_orow, a_err, a_st};
      e = '0;
      e_xhs = 1'b0; e_whs = 1'b0; e_clr = 1'b0; e_uf = 1'b0;
      if (!rst) begin
         e.err = m_err;
         e.st  = 2'(m_ph);
         case (m_ph)
            0: begin
               e.xr   = (m_xc < KK) && (x_full != 4'hF);
               e.wr   = (m_wc < KK) && (w_full != 4'hF);
               e_xhs  = x_val && e.xr;
               e_whs  = w_val && e.wr;
               e.xwen = {4{e_xhs}};
               e.wwen = {4{e_whs}};
               e_clr  = (m_xc + int'(e_xhs) == KK) && (m_wc + int'(e_whs) == KK);
               e.mclr = e_clr;
            end
            1: begin
               e.men = 1'b1;
               for (int i = 0; i < R; i++) e.xren[i] = (m_c >= i) && (m_c < i + KK);
               for (int j = 0; j < C; j++) e.wren[j] = (m_c >= j) && (m_c < j + KK);
               e_uf = ((e.xren & x_empty) != 4'h0) || ((e.wren & w_empty) != 4'h0);
            end
            default: begin
               e.oval = 1'b1;
               e.orow = 2'(m_r);
            end
         endcase
      end
      chk("cycle", 32'(snap), 32'(e));
      @(posedge clk);
      if (rst) begin
         m_ph = 0; m_xc = 0; m_wc = 0; m_c = 0; m_r = 0; m_err = 1'b0;
      end else begin
         case (m_ph)
            0: begin
               m_xc += int'(e_xhs);
               m_wc += int'(e_whs);
               if (e_clr) begin m_ph = 1; m_c = 0; end
            end
            1: begin
               if (e_uf) m_err = 1'b1;
               m_c++;
               if (m_c == L) begin m_ph = 2; m_r = 0; end
            end
            default: begin
               if (out_rdy) begin
                  m_r++;
                  if (m_r == R) begin m_ph = 0; m_xc = 0; m_wc = 0; end
               end
            end
         endcase
      end
      #1;
   endtask

   // Parallel load, full MAC window (optionally emptying x lane 1 at one cycle), drain with rdy high.
   task automatic run_tile(input int empty_c);
      x_val = 1'b1; w_val = 1'b1; out_rdy = 1'b1;
      for (int k = 0; k < KK; k++) begin
         tick();
         if (k == KK - 1) chk("par_clr", 32'(snap.mclr), 32'd1);
      end
      x_val = 1'b0; w_val = 1'b0;
      for (int c = 0; c < L; c++) begin
         x_empty = (c == empty_c) ? 4'b0010 : 4'b0000;
         tick();
         if (c == 0) chk("mac_start", 32'(snap.st), 32'd1);
         if (empty_c >= 0 && c == empty_c) chk("err_before", 32'(snap.err), 32'd0);
         if (empty_c >= 0 && c == empty_c + 1) chk("err_rise", 32'(snap.err), 32'd1);
      end
      x_empty = 4'b0000;
      for (int k = 0; k < R; k++) begin
         tick();
         chk("drain_row", 32'(snap.orow), 32'(k));
      end
      tick();
      chk("back_to_load", 32'(snap.st), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[8];
      int   xw, ww, men_cnt, n, len;

      // x: one blocked cycle (all full), then 4 back-to-back beats; w: val every other cycle.
      tv[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
      tv[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
      tv[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
      tv[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
      tv[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
      tv[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
      tv[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
      tv[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};

      rst = 1'b1; x_val = 1'b0; w_val = 1'b0; out_rdy = 1'b0;
      x_full = 4'h0; w_full = 4'h0; x_empty = 4'h0; w_empty = 4'h0;
      @(posedge clk); #1;

      // Reset and idle.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_zero", 32'(snap), 32'd0);
      end
      rst = 1'b0;
      tick();
      chk("idle_xrdy", 32'(snap.xr), 32'd1);
      chk("idle_wrdy", 32'(snap.wr), 32'd1);
      chk("idle_state", 32'(snap.st), 32'd0);

      // Non-square instance: one MAC window should last K+ROWS+COLS = 10 cycles.
      n = 0;
      while (!b_men && n < 60) begin tick(); n++; end
      chk("b_mac_seen", 32'(b_men), 32'd1);
      len = 0;
      while (b_men && len < 60) begin tick(); len++; end
      chk("b_mac_len", 32'(len), 32'd10);

      // Tile 1: counted load with skew, from the vector table.
      xw = 0; ww = 0;
      for (int i = 0; i < 8; i++) begin
         x_val  = tv[i].xv;
         w_val  = tv[i].wv;
         x_full = tv[i].xfull ? 4'hF : 4'h0;
         tick();
         chk("ld_xrdy", 32'(snap.xr), 32'(tv[i].exr));
         chk("ld_wrdy", 32'(snap.wr), 32'(tv[i].ewr));
         chk("ld_clr", 32'(snap.mclr), 32'(tv[i].eclr));
         chk("ld_state", 32'(snap.st), 32'(tv[i].est));
         if (tv[i].xfull) chk("full_no_wen", 32'(snap.xwen), 32'd0);
         if (snap.xwen != 4'h0) xw++;
         if (snap.wwen != 4'h0) ww++;
      end
      x_full = 4'h0; x_val = 1'b0; w_val = 1'b0; out_rdy = 1'b0;
      chk("x_wen_cycles", 32'(xw), 32'd4);
      chk("w_wen_cycles", 32'(ww), 32'd4);

      // MAC window shape.
      men_cnt = 0;
      for (int c = 0; c < L; c++) begin
         tick();
         chk("mac_state", 32'(snap.st), 32'd1);
         chk("xren2", 32'(snap.xren[2]), 32'(c >= 2 && c <= 5));
         chk("wren3", 32'(snap.wren[3]), 32'(c >= 3 && c <= 6));
         men_cnt += int'(snap.men);
      end

      // Output backpressure, then one row per cycle.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_val", 32'(snap.oval), 32'd1);
         chk("bp_row", 32'(snap.orow), 32'd0);
         men_cnt += int'(snap.men);
      end
      out_rdy = 1'b1;
      for (int k = 0; k < R; k++) begin
         tick();
         chk("out_row", 32'(snap.orow), 32'(k));
         men_cnt += int'(snap.men);
      end
      tick();
      chk("tile1_done", 32'(snap.st), 32'd0);
      chk("mac_en_cycles", 32'(men_cnt), 32'd12);

      // Tile 2 with underflow at c=1, tile 3 must keep err set.
      run_tile(1);
      run_tile(-1);
      chk("err_sticky", 32'(snap.err), 32'd1);

      // Reset in the middle of MAC.
      x_val = 1'b1; w_val = 1'b1;
      for (int k = 0; k < KK; k++) tick();
      x_val = 1'b0; w_val = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      chk("pre_rst_mac", 32'(snap.st), 32'd1);
      rst = 1'b1;
      tick();
      chk("rst_mid0", 32'(snap), 32'd0);
      tick();
      chk("rst_mid1", 32'(snap), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_state", 32'(snap.st), 32'd0);
      chk("post_rst_xrdy", 32'(snap.xr), 32'd1);
      run_tile(-1);
      chk("post_rst_err", 32'(snap.err), 32'd0);

      // Random traffic against the model.
      for (int n2 = 0; n2 < 1500; n2++) begin
         rst     = ($urandom_range(0, 299) == 0);
         x_val   = 1'($urandom_range(0, 1));
         w_val   = 1'($urandom_range(0, 1));
         out_rdy = 1'($urandom_range(0, 1));
         x_full  = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
         w_full  = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
         x_empty = ($urandom_range(0, 40) == 0) ? 4'($urandom) : 4'h0;
         w_empty = ($urandom_range(0, 40) == 0) ? 4'($urandom) : 4'h0;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/systolic_tile_ctrl.md
# systolic_tile_ctrl

Control FSM for a parametrised ROWS×COLS output-stationary systolic array with per-tile operand depth K. It accepts K operand beats per tile on independent x (row) and w (column) streams into per-lane FIFOs, then issues diagonally skewed FIFO read enables and a timed MAC window. It streams the ROWS result rows out over a val/rdy handshake and returns to LOAD for the next tile. It replaces the single-shot square controller: non-square arrays, counted loads, accumulator clear, result drain and an underflow flag.

## Interface
- ROWS, default 4: number of x lanes / array rows (≥1)
- COLS, default 4: number of w lanes / array columns (≥1)
- K, default 4: operand beats per lane per tile (≥1, ≤ FIFO depth)
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- x_recv_val / x_recv_rdy  in / out  1 / 1  x beat handshake; one beat writes all ROWS x FIFOs
- w_recv_val / w_recv_rdy  in / out  1 / 1  w beat handshake; one beat writes all COLS w FIFOs
- x_fifo_full, x_fifo_empty  in  1 [ROWS]  x FIFO status
- x_fifo_wen, x_fifo_ren  out  1 [ROWS]  x FIFO write/read enables
- w_fifo_full, w_fifo_empty  in  1 [COLS]  w FIFO status
- w_fifo_wen, w_fifo_ren  out  1 [COLS]  w FIFO write/read enables
- mac_en  out  1  PE accumulate enable
- mac_clr  out  1  one-cycle PE accumulator clear
- out_send_val / out_send_rdy  out / in  1 / 1  result row handshake
- out_row  out  max(1,$clog2(ROWS))  index of row being presented
- err  out  1  sticky underflow flag
- state_o  out  2  LOAD=0, MAC=1, OUT=2 (trace)

## Operation
- State LOAD: counters xc, wc (0..K).
  - x_recv_rdy = LOAD & (xc<K) & ~(AND of x_fifo_full).
  - x_fifo_wen[i] = x_recv_val & x_recv_rdy for all i.
  - xc increments on each x handshake. The w side is identical and independent.
  - When xc==K and wc==K: mac_clr=1 this cycle; next state MAC; c←0.
- State MAC: cycle counter c runs 0..L-1, L = K+ROWS+COLS.
  - x_fifo_ren[i] = (i ≤ c < i+K).
  - w_fifo_ren[j] = (j ≤ c < j+K).
  - The enables are combinational from state and c.
  - mac_en=1 for all L cycles.
  - At c==L-1: next state OUT; r←0.
- State OUT:
  - out_send_val=1; out_row=r; mac_en=0, so accumulators hold.
  - On val&rdy: r increments.
  - Accepting row ROWS-1 moves to LOAD with xc=wc=0.
- err: set when any ren[k] is high while the matching empty[k] is high. It stays set until rst. The FSM does not stall on err.
- Recv rdy signals and all wen signals are 0 outside LOAD. Ren signals are 0 outside MAC.

## Timing
- While rst is high, every output is 0.
- First cycle after rst falls: state LOAD, counters 0, err 0. x_recv_rdy/w_recv_rdy are 1 iff not all of their FIFOs are full.
- Ready is combinational; a beat transfers in the cycle val&rdy.
- Beat K transfers and rdy drops the next cycle.
- x and w may finish loading in different cycles; the LOAD→MAC edge follows the later one.
- mac_clr is high only in the final LOAD cycle. The first ren (x[0], w[0]) is in MAC cycle c=0.
- FIFO read data is valid one cycle after ren; the PE array handles that latency. The L window covers read latency plus ROWS+COLS skew.
- MAC duration is exactly L cycles, independent of handshakes.
- Out rows: one per cycle with rdy held high; out_row is stable while val&~rdy.
- Minimum tile period: 2K (serial) or K (parallel) load cycles + L + ROWS.
- rst mid-tile aborts immediately to LOAD with zero counters. FIFO contents are not the block's responsibility.
- ROWS=1: out_row is a constant 0, and the single row handshake returns to LOAD.

## Test plan
- Reset/idle, ROWS=COLS=K=4, FIFOs empty:
  - All outputs are 0 during rst.
  - Next cycle: x_recv_rdy=w_recv_rdy=1, state_o=0.
- Counted load with skew:
  - Stimulus: 4 x beats back-to-back, w beats with val toggled every other cycle.
  - x_recv_rdy falls after the 4th x beat. wen fires on exactly 4 cycles per side.
  - mac_clr pulses once in the cycle of the 8th total beat; state_o=1 the next cycle.
- MAC window:
  - x_fifo_ren[2] is high only at c=2..5, and w_fifo_ren[3] only at c=3..6.
  - mac_en is high exactly 12 cycles.
  - Repeat with ROWS=2, COLS=5, K=3: mac_en is high 10 cycles.
- Output backpressure:
  - Stimulus: out_send_rdy low 3 cycles, then high.
  - out_row holds 0, then steps 0,1,2,3 on consecutive cycles.
  - state_o=0 next, and a second tile completes identically.
- Full backpressure and underflow:
  - All x_fifo_full high in LOAD → x_recv_rdy=0 and no x_fifo_wen.
  - x_fifo_empty[1] high at c=1 → err=1, stays 1 through the next tile.
- Reset mid-MAC:
  - Stimulus: rst asserted at c=5.
  - Next cycle all outputs are 0; after release, a full tile runs normally with err=0.
